// File: rtl/adc_capture_pkg.sv
// Shared types and default widths for the ADC capture block.
package adc_capture_pkg;

   localparam int unsigned DefDw = 12;
   localparam int unsigned DefAw = 10;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StArmed   = 2'd1,
      StCapture = 2'd2,
      StFull    = 2'd3
   } state_e;

endpackage

// File: rtl/adc_capture_if.sv
// ADC pins, capture control/status and the record read port of adc_capture.
interface adc_capture_if
   import adc_capture_pkg::*;
#(
   parameter int unsigned DW = DefDw,
   parameter int unsigned AW = DefAw
);
   logic          ad_clk;
   logic [DW-1:0] ad_data;
   logic          ad_otr;
   logic          arm;
   logic          auto_trig;
   logic [DW-1:0] trig_level;
   logic          busy;
   logic          done;
   logic          forced;
   logic          ovr;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;

   modport master (
      input  ad_clk, busy, done, forced, ovr, rd_data,
      output ad_data, ad_otr, arm, auto_trig, trig_level, rd_addr
   );

   modport slave (
      output ad_clk, busy, done, forced, ovr, rd_data,
      input  ad_data, ad_otr, arm, auto_trig, trig_level, rd_addr
   );

endinterface

// File: rtl/adc_capture_ram.sv
// Simple dual-port record buffer: one write port, one registered read port (read-before-write).
module adc_capture_ram #(
   parameter int unsigned DW = 12,
   parameter int unsigned AW = 10
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          we_i,
   input  logic [AW-1:0] wr_addr_i,
   input  logic [DW-1:0] wr_data_i,
   input  logic [AW-1:0] rd_addr_i,
   output logic [DW-1:0] rd_data_o
);
   logic [DW-1:0] mem [2**AW];
   logic [DW-1:0] rd_data_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem[wr_addr_i] <= wr_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= mem[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/adc_capture.sv
// ADC receive path: generates AD_CLK, samples the converter and records 2**AW samples
// after a rising level crossing (or a timeout) into a local buffer.
module adc_capture
   import adc_capture_pkg::*;
#(
   parameter int unsigned DW  = DefDw,
   parameter int unsigned AW  = DefAw,
   parameter int unsigned DIV = 2,
   parameter int unsigned TMO = 24
) (
   input  logic         clk_i,
   input  logic         rst_i,
   adc_capture_if.slave bus
);
   logic [7:0]     div_cnt_q, div_cnt_d;
   logic           ad_clk_q, div_wrap, strobe, smp_q;
   logic [DW-1:0]  s_cur_q, s_prev_q, lvl_q, lvl_d;
   logic           o_cur_q;
   logic           primed_q, primed_d;
   logic [TMO-1:0] tmo_cnt_q, tmo_cnt_d;
   logic [AW-1:0]  wr_addr_q, wr_addr_d;
   logic           forced_q, forced_d, ovr_q, ovr_d;
   logic           ram_we, xing, tmo_full;
   state_e         state_q, state_d;

   assign div_wrap  = (div_cnt_q == 8'(DIV - 1));
   assign div_cnt_d = div_wrap ? 8'd0 : div_cnt_q + 8'd1;
   assign strobe    = div_wrap & ~ad_clk_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         div_cnt_q <= '0;
         ad_clk_q  <= 1'b0;
         smp_q     <= 1'b0;
         s_cur_q   <= '0;
         s_prev_q  <= '0;
         o_cur_q   <= 1'b0;
      end else begin
         div_cnt_q <= div_cnt_d;
         ad_clk_q  <= ad_clk_q ^ div_wrap;
         smp_q     <= strobe;
         if (strobe) begin
            s_cur_q  <= bus.ad_data;
            s_prev_q <= s_cur_q;
            o_cur_q  <= bus.ad_otr;
         end
      end
   end

   // Qualified one cycle after the strobe, so the pair already holds the newest sample.
   assign xing     = smp_q & primed_q & (s_prev_q < lvl_q) & (s_cur_q >= lvl_q);
   assign tmo_full = &tmo_cnt_q;

   always_comb begin
      state_d   = state_q;
      wr_addr_d = wr_addr_q;
      tmo_cnt_d = tmo_cnt_q;
      primed_d  = primed_q | smp_q;
      lvl_d     = lvl_q;
      forced_d  = forced_q;
      ovr_d     = ovr_q;
      ram_we    = 1'b0;
      unique case (state_q)
         StArmed: begin
            if (smp_q && !tmo_full) begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
            if (xing || (bus.auto_trig && tmo_full)) begin
               state_d   = StCapture;
               ram_we    = 1'b1;
               wr_addr_d = wr_addr_q + 1'b1;
               forced_d  = ~xing;
               ovr_d     = ovr_q | o_cur_q;
            end
         end
         StCapture: begin
            if (smp_q) begin
               ram_we    = 1'b1;
               wr_addr_d = wr_addr_q + 1'b1;
               ovr_d     = ovr_q | o_cur_q;
               if (&wr_addr_q) begin
                  state_d = StFull;
               end
            end
         end
         StIdle, StFull: ;
      endcase
      // A new arm restarts from any state and discards any partial record.
      if (bus.arm) begin
         state_d   = StArmed;
         wr_addr_d = '0;
         tmo_cnt_d = '0;
         primed_d  = 1'b0;
         lvl_d     = bus.trig_level;
         ovr_d     = 1'b0;
         ram_we    = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= StIdle;
         wr_addr_q <= '0;
         tmo_cnt_q <= '0;
         primed_q  <= 1'b0;
         lvl_q     <= '0;
         forced_q  <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_addr_q <= wr_addr_d;
         tmo_cnt_q <= tmo_cnt_d;
         primed_q  <= primed_d;
         lvl_q     <= lvl_d;
         forced_q  <= forced_d;
         ovr_q     <= ovr_d;
      end
   end

   adc_capture_ram #(
      .DW (DW),
      .AW (AW)
   ) u_ram (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .we_i      (ram_we),
      .wr_addr_i (wr_addr_q),
      .wr_data_i (s_cur_q),
      .rd_addr_i (bus.rd_addr),
      .rd_data_o (bus.rd_data)
   );

   assign bus.ad_clk = ad_clk_q;
   assign bus.busy   = (state_q == StArmed) || (state_q == StCapture);
   assign bus.done   = (state_q == StFull);
   assign bus.forced = forced_q;
   assign bus.ovr    = ovr_q;

endmodule
